// File: rtl/pq_pkg.sv
// Shared types for the priority-queue sorter: key/value pair layout,
// reserved sentinel keys and the default queue depth.
package pq_pkg;
   localparam int PQ_CAPACITY = 4;
   localparam int KEY_W       = 8;
   localparam int VAL_W       = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   // KEY0 marks reset-time dummies, KEYINF marks a free slot.
   localparam logic [KEY_W-1:0] KEY0   = '0;
   localparam logic [KEY_W-1:0] KEYINF = '1;
endpackage

// File: rtl/pq_sort_client_if.sv
// Bundles the input stream, output stream, PQ request/response signals and
// status flags of pq_sort_client; master is the client side, slave the environment.
interface pq_sort_client_if;
   import pq_pkg::*;

   // Streams: a pair moves on a rising edge where valid && ready are both high;
   // the source keeps payload stable while valid && !ready.
   logic       in_valid;
   logic       in_ready;
   kv_t        in_kv;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   kv_t        out_kv;
   logic       out_last;
   logic       pq_replace;
   logic       pq_deq;
   kv_t        pq_kvi;
   kv_t        pq_kvo;
   logic       pq_full;
   logic       pq_empty;
   logic       pq_busy;
   logic       err_key;
   logic       err_ovf;
   logic       err_sync;
   logic [1:0] dbg_state;

   modport master (
      input  in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
      output in_ready, out_valid, out_kv, out_last, pq_replace, pq_deq, pq_kvi,
             err_key, err_ovf, err_sync, dbg_state
   );

   modport slave (
      output in_valid, in_kv, in_last, out_ready, pq_kvo, pq_full, pq_empty, pq_busy,
      input  in_ready, out_valid, out_kv, out_last, pq_replace, pq_deq, pq_kvi,
             err_key, err_ovf, err_sync, dbg_state
   );
endinterface

// File: rtl/pq_sort_client.sv
// Host side of a register-array min-PQ: loads a keyed batch with replace ops,
// then drains it with dequeues to emit the pairs in ascending key order.
module pq_sort_client #(
   parameter int CAPACITY = pq_pkg::PQ_CAPACITY,
   parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
   input logic              clk,
   input logic              rst,
   pq_sort_client_if.master bus
);
   import pq_pkg::*;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] init_cnt_q;
   logic             first_load_q;
   logic             out_valid_q;
   logic             out_last_q;
   kv_t              out_kv_q;
   logic             err_key_q;
   logic             err_ovf_q;
   logic             err_sync_q;

   logic             reserved_c;
   logic             in_ready_c;
   logic             accept_c;
   logic             do_rep_c;
   logic             init_deq_c;
   logic             drain_issue_c;
   logic [CNT_W-1:0] cnt_inc_c;

   always_comb begin
      reserved_c    = (bus.in_kv.key == KEY0) || (bus.in_kv.key == KEYINF);
      in_ready_c    = (state_q == S_LOAD) && !bus.pq_busy && (cnt_q < CAP_C);
      accept_c      = bus.in_valid && in_ready_c;
      do_rep_c      = accept_c && !reserved_c;
      cnt_inc_c     = cnt_q + (do_rep_c ? ONE_C : '0);
      // The PQ is held in reset by the same rst, so no flush request may leak out.
      init_deq_c    = (state_q == S_INIT) && !bus.pq_busy && !rst;
      drain_issue_c = (state_q == S_DRAIN) && (cnt_q != '0) && !bus.pq_busy
                      && (!out_valid_q || bus.out_ready);
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.pq_replace = do_rep_c;
   assign bus.pq_deq     = init_deq_c || drain_issue_c;
   assign bus.pq_kvi     = do_rep_c ? bus.in_kv : '0;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_kv     = out_kv_q;
   assign bus.out_last   = out_last_q;
   assign bus.err_key    = err_key_q;
   assign bus.err_ovf    = err_ovf_q;
   assign bus.err_sync   = err_sync_q;
   assign bus.dbg_state  = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         cnt_q        <= '0;
         init_cnt_q   <= '0;
         first_load_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_kv_q     <= '0;
         out_last_q   <= 1'b0;
         err_key_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_sync_q   <= 1'b0;
      end else begin
         // Output register runs in every state so a last pair can linger into LOAD.
         if (drain_issue_c) begin
            out_valid_q <= 1'b1;
            out_kv_q    <= bus.pq_kvo;
            out_last_q  <= (cnt_q == ONE_C);
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         first_load_q <= 1'b0;

         case (state_q)
            S_INIT: begin
               if (init_deq_c) begin
                  init_cnt_q <= init_cnt_q + ONE_C;
                  if (init_cnt_q == CAP_C - ONE_C) begin
                     state_q      <= S_LOAD;
                     first_load_q <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (first_load_q && !bus.pq_empty) begin
                  err_sync_q <= 1'b1;
               end
               if (accept_c) begin
                  if (reserved_c) begin
                     err_key_q <= 1'b1;
                  end
                  cnt_q <= cnt_inc_c;
                  if (bus.in_last && (cnt_inc_c != '0)) begin
                     state_q <= S_DRAIN;
                  end else if (do_rep_c && (cnt_inc_c == CAP_C)) begin
                     // Queue is full mid-batch: sort what we have, the rest becomes a new batch.
                     state_q   <= S_DRAIN;
                     err_ovf_q <= 1'b1;
                  end
               end
            end

            S_DRAIN: begin
               if (drain_issue_c) begin
                  cnt_q <= cnt_q - ONE_C;
                  if (bus.pq_empty) begin
                     err_sync_q <= 1'b1;
                  end
                  if (cnt_q == ONE_C) begin
                     state_q <= S_LOAD;
                  end
               end
            end

            default: state_q <= S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_rep_c) begin
         assert (!bus.pq_full);
      end
   end

endmodule

// File: tb/tb_pq_sort_client.sv
// Bench for pq_sort_client with an attached min-PQ model, hand-checked vector
// table, stall/reset sequences and a randomized run against a batch-sort model.
`timescale 1ns/1ps
module tb_pq_sort_client;
   import pq_pkg::*;

   localparam int CAP = 4;
   localparam int EW  = 17;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pq_sort_client_if ifc ();

   pq_sort_client #(.CAPACITY(CAP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
   );

   // ---------------- attached priority queue model ----------------
   // Fixed number of slots; replace overwrites the largest slot, dequeue frees the smallest.
   kv_t pq_mem [CAP];
   int  min_idx;
   int  max_idx;

   always_comb begin
      min_idx = 0;
      max_idx = 0;
      for (int i = 1; i < CAP; i++) begin
         if (pq_mem[i].key < pq_mem[min_idx].key) min_idx = i;
         if (pq_mem[i].key > pq_mem[max_idx].key) max_idx = i;
      end
   end

   always_comb begin
      ifc.pq_kvo   = pq_mem[min_idx];
      ifc.pq_empty = 1'b1;
      ifc.pq_full  = 1'b1;
      for (int i = 0; i < CAP; i++) begin
         if (pq_mem[i].key != KEYINF) ifc.pq_empty = 1'b0;
         else                         ifc.pq_full  = 1'b0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CAP; i++) pq_mem[i] <= '0;
      end else if (ifc.pq_replace) begin
         pq_mem[max_idx] <= ifc.pq_kvi;
      end else if (ifc.pq_deq) begin
         pq_mem[min_idx] <= kv_t'({KEYINF, 8'h00});
      end
   end

   // ---------------- counters, monitor ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int deq_cnt = 0, rep_cnt = 0, proto_bad = 0, stab_bad = 0, stall_seen = 0;
   logic [EW-1:0] got_q [$];
   int            got_cyc [$];
   logic          stall_prev = 1'b0;
   logic [EW-1:0] stall_val = '0;
   logic          rnd_on = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 1'b0;
         end else begin
            if (ifc.pq_deq) deq_cnt++;
            if (ifc.pq_replace) rep_cnt++;
            if ((ifc.pq_deq && ifc.pq_replace) || (ifc.pq_busy && (ifc.pq_deq || ifc.pq_replace)))
               proto_bad++;
            if (stall_prev) begin
               stall_seen++;
               if (!ifc.out_valid || ({ifc.out_last, ifc.out_kv} !== stall_val)) stab_bad++;
            end
            stall_prev = ifc.out_valid && !ifc.out_ready;
            stall_val  = {ifc.out_last, ifc.out_kv};
            if (ifc.out_valid && ifc.out_ready) begin
               got_q.push_back({ifc.out_last, ifc.out_kv});
               got_cyc.push_back(cyc);
            end
         end
      end
   end

   // Random backpressure and PQ busy while the randomized phase runs.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_on) begin
            ifc.pq_busy   = ($urandom_range(0, 3) == 0);
            ifc.out_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic kv_t mk_kv(input logic [7:0] k);
      mk_kv = kv_t'({k, k ^ 8'h5A});
   endfunction

   task automatic send_pair(input kv_t kv, input logic last, output logic ok);
      int n;
      n  = 0;
      ok = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_kv    = kv;
      ifc.in_last  = last;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (ifc.in_ready) ok = 1'b1;
         n++;
      end
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      ifc.in_last  = 1'b0;
   endtask

   task automatic wait_init(input string name);
      int n;
      n = 0;
      while (!ifc.in_ready && n < 50) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check({name, " init deqs"}, deq_cnt, CAP);
      check({name, " in_ready"}, ifc.in_ready, 1);
      check({name, " pq_empty"}, ifc.pq_empty, 1);
      check({name, " err_sync"}, ifc.err_sync, 0);
      check({name, " state LOAD"}, ifc.dbg_state, 1);
   endtask

   task automatic wait_outputs(input int cnt);
      int n;
      n = 0;
      while (got_q.size() < cnt && n < 200) begin
         tick();
         n++;
      end
      repeat (6) tick();
   endtask

   task automatic expect_out(input string name, input int idx, input logic [7:0] k, input logic last);
      logic [EW-1:0] g;
      g = (idx < got_q.size()) ? got_q[idx] : '1;
      check({name, " key"}, g[15:8], k);
      check({name, " val"}, g[7:0], k ^ 8'h5A);
      check({name, " last"}, g[16], last);
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic [3:0]      n_in;
      logic [7:0][7:0] in_key;
      logic [3:0]      n_out;
      logic [7:0][7:0] out_key;
      logic [7:0]      last_mask;
      logic            e_key;
      logic            e_ovf;
   } vec_t;

   vec_t vecs [5];

   function automatic logic [7:0][7:0] k6(input logic [7:0] a, b, c, d, e, f);
      k6 = '0;
      k6[0] = a; k6[1] = b; k6[2] = c; k6[3] = d; k6[4] = e; k6[5] = f;
   endfunction

   task automatic run_vec(input int v);
      logic ok;
      got_q.delete();
      got_cyc.delete();
      deq_cnt = 0;
      rep_cnt = 0;
      for (int i = 0; i < int'(vecs[v].n_in); i++) begin
         send_pair(mk_kv(vecs[v].in_key[i]), (i == int'(vecs[v].n_in) - 1), ok);
         check($sformatf("vec%0d accept%0d", v, i), ok, 1);
      end
      wait_outputs(int'(vecs[v].n_out));
      check($sformatf("vec%0d out count", v), got_q.size(), vecs[v].n_out);
      for (int j = 0; j < int'(vecs[v].n_out); j++)
         expect_out($sformatf("vec%0d out%0d", v, j), j, vecs[v].out_key[j], vecs[v].last_mask[j]);
      check($sformatf("vec%0d replaces", v), rep_cnt, vecs[v].n_out);
      check($sformatf("vec%0d deqs", v), deq_cnt, vecs[v].n_out);
      check($sformatf("vec%0d err_key", v), ifc.err_key, vecs[v].e_key);
      check($sformatf("vec%0d err_ovf", v), ifc.err_ovf, vecs[v].e_ovf);
      check($sformatf("vec%0d err_sync", v), ifc.err_sync, 0);
      check($sformatf("vec%0d state", v), ifc.dbg_state, 1);
      check($sformatf("vec%0d out_valid idle", v), ifc.out_valid, 0);
   endtask

   // ---------------- reference model for the random phase ----------------
   logic [EW-1:0] exp_q [$];
   kv_t           m_batch [$];
   logic          m_err_key = 1'b0;
   logic          m_err_ovf = 1'b0;

   task automatic model_flush();
      int mi;
      while (m_batch.size() > 0) begin
         mi = 0;
         for (int i = 1; i < m_batch.size(); i++)
            if (m_batch[i].key < m_batch[mi].key) mi = i;
         exp_q.push_back({(m_batch.size() == 1), m_batch[mi]});
         m_batch.delete(mi);
      end
   endtask

   task automatic model_accept(input kv_t kv, input logic last);
      logic rsv;
      rsv = (kv.key == KEY0) || (kv.key == KEYINF);
      if (rsv) m_err_key = 1'b1;
      else     m_batch.push_back(kv);
      if (!rsv && !last && m_batch.size() == CAP) begin
         m_err_ovf = 1'b1;
         model_flush();
      end else if (last && m_batch.size() > 0) begin
         model_flush();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic          ok;
      int            n;
      logic [3:0]    pat;
      logic [7:0]    k;
      logic [EW-1:0] g;
      bit            used_k [256];

      ifc.in_valid  = 1'b0;
      ifc.in_kv     = '0;
      ifc.in_last   = 1'b0;
      ifc.out_ready = 1'b1;
      ifc.pq_busy   = 1'b0;

      vecs[0] = '{n_in: 4'd4, in_key: k6(9, 3, 7, 5, 0, 0), n_out: 4'd4,
                  out_key: k6(3, 5, 7, 9, 0, 0), last_mask: 8'b0000_1000, e_key: 1'b0, e_ovf: 1'b0};
      vecs[1] = '{n_in: 4'd1, in_key: k6(1, 0, 0, 0, 0, 0), n_out: 4'd1,
                  out_key: k6(1, 0, 0, 0, 0, 0), last_mask: 8'b0000_0001, e_key: 1'b0, e_ovf: 1'b0};
      vecs[2] = '{n_in: 4'd6, in_key: k6(8, 1, 4, 2, 9, 3), n_out: 4'd6,
                  out_key: k6(1, 2, 4, 8, 3, 9), last_mask: 8'b0010_1000, e_key: 1'b0, e_ovf: 1'b1};
      vecs[3] = '{n_in: 4'd3, in_key: k6(8'h00, 5, 8'hFF, 0, 0, 0), n_out: 4'd1,
                  out_key: k6(5, 0, 0, 0, 0, 0), last_mask: 8'b0000_0001, e_key: 1'b1, e_ovf: 1'b1};
      vecs[4] = '{n_in: 4'd1, in_key: k6(8'hFF, 0, 0, 0, 0, 0), n_out: 4'd0,
                  out_key: '0, last_mask: 8'b0000_0000, e_key: 1'b1, e_ovf: 1'b1};

      // Reset values, then the INIT flush.
      tick();
      tick();
      check("rst out_valid", ifc.out_valid, 0);
      check("rst out_kv", ifc.out_kv, 0);
      check("rst out_last", ifc.out_last, 0);
      check("rst in_ready", ifc.in_ready, 0);
      check("rst pq_deq", ifc.pq_deq, 0);
      check("rst pq_replace", ifc.pq_replace, 0);
      check("rst pq_kvi", ifc.pq_kvi, 0);
      check("rst errs", {ifc.err_key, ifc.err_ovf, ifc.err_sync}, 0);
      check("rst state", ifc.dbg_state, 0);
      deq_cnt = 0;
      rst = 1'b0;
      wait_init("boot");

      // Unstalled 4-pair batch: one output per cycle.
      run_vec(0);
      check("vec0 back-to-back", (got_cyc.size() >= 4) ? (got_cyc[3] - got_cyc[0]) : -1, 3);

      // Output stall: pairs held while out_ready is low.
      ifc.out_ready = 1'b0;
      got_q.delete();
      stall_seen = 0;
      send_pair(mk_kv(8'd6), 1'b0, ok);
      check("stall accept0", ok, 1);
      send_pair(mk_kv(8'd2), 1'b1, ok);
      check("stall accept1", ok, 1);
      n = 0;
      while (!ifc.out_valid && n < 50) begin
         tick();
         n++;
      end
      check("stall first valid", ifc.out_valid, 1);
      check("stall first kv", ifc.out_kv, mk_kv(8'd2));
      pat = 4'b1001;
      for (int p = 3; p >= 0; p--) begin
         ifc.out_ready = pat[p];
         tick();
      end
      ifc.out_ready = 1'b1;
      wait_outputs(2);
      check("stall out count", got_q.size(), 2);
      expect_out("stall out0", 0, 8'd2, 1'b0);
      expect_out("stall out1", 1, 8'd6, 1'b1);
      check("stall cycles observed", (stall_seen >= 2), 1);

      for (int v = 1; v < 5; v++) run_vec(v);

      // Reset in the middle of a drain.
      got_q.delete();
      send_pair(mk_kv(8'd10), 1'b0, ok);
      send_pair(mk_kv(8'd20), 1'b0, ok);
      send_pair(mk_kv(8'd30), 1'b0, ok);
      send_pair(mk_kv(8'd40), 1'b1, ok);
      check("mid accept", ok, 1);
      n = 0;
      while (got_q.size() < 2 && n < 50) begin
         tick();
         n++;
      end
      check("mid out_valid before rst", ifc.out_valid, 1);
      rst = 1'b1;
      #1;
      check("mid rst out_valid", ifc.out_valid, 0);
      check("mid rst pq_deq", ifc.pq_deq, 0);
      check("mid rst in_ready", ifc.in_ready, 0);
      expect_out("mid out0", 0, 8'd10, 1'b0);
      expect_out("mid out1", 1, 8'd20, 1'b0);
      tick();
      tick();
      check("mid rst errs cleared", {ifc.err_key, ifc.err_ovf, ifc.err_sync}, 0);
      deq_cnt = 0;
      got_q.delete();
      rst = 1'b0;
      wait_init("rerun");
      send_pair(mk_kv(8'd4), 1'b0, ok);
      send_pair(mk_kv(8'd1), 1'b1, ok);
      wait_outputs(2);
      check("post rst count", got_q.size(), 2);
      expect_out("post rst out0", 0, 8'd1, 1'b0);
      expect_out("post rst out1", 1, 8'd4, 1'b1);

      // Randomized batches with busy and backpressure.
      got_q.delete();
      exp_q.delete();
      m_batch.delete();
      m_err_key = 1'b0;
      m_err_ovf = 1'b0;
      rnd_on = 1'b1;
      for (int b = 0; b < 14; b++) begin
         int sz;
         sz = $urandom_range(1, 6);
         foreach (used_k[i]) used_k[i] = 1'b0;
         for (int i = 0; i < sz; i++) begin
            if ($urandom_range(0, 7) == 0) begin
               k = ($urandom_range(0, 1) == 1) ? KEYINF : KEY0;
            end else begin
               k = 8'($urandom_range(1, 254));
               while (used_k[k]) k = 8'($urandom_range(1, 254));
               used_k[k] = 1'b1;
            end
            send_pair(mk_kv(k), (i == sz - 1), ok);
            check($sformatf("rnd b%0d accept%0d", b, i), ok, 1);
            if (ok) model_accept(mk_kv(k), (i == sz - 1));
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      rnd_on = 1'b0;
      tick();
      tick();
      ifc.pq_busy   = 1'b0;
      ifc.out_ready = 1'b1;
      n = 0;
      while (got_q.size() < exp_q.size() && n < 3000) begin
         tick();
         n++;
      end
      repeat (6) tick();
      check("rnd out count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : '1;
         check($sformatf("rnd out%0d", i), g, exp_q[i]);
      end
      check("rnd err_key", ifc.err_key, m_err_key);
      check("rnd err_ovf", ifc.err_ovf, m_err_ovf);
      check("rnd err_sync", ifc.err_sync, 0);
      check("rnd state LOAD", ifc.dbg_state, 1);

      check("protocol violations", proto_bad, 0);
      check("stall stability", stab_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      n_bad++;
      $display("FAIL watchdog: got timeout, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
